// File: rtl/pieo_op_scheduler.sv
// PIEO scheduler front-end: arbitrates enqueue/dequeue requesters, serialises one
// core operation at a time, and tracks list occupancy for full/empty gating.
module pieo_op_scheduler #(
  parameter int NUM_ENQ      = 4,
  parameter int ID_LOG       = 7,
  parameter int RANK_LOG     = 8,
  parameter int STARVE_LIMIT = 8,
  localparam int PTR_W       = (NUM_ENQ > 1) ? $clog2(NUM_ENQ) : 1,
  localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_ENQ-1:0]           enq_valid,
  output logic [NUM_ENQ-1:0]           enq_ready,
  input  logic [NUM_ENQ*ID_LOG-1:0]    enq_id,
  input  logic [NUM_ENQ*RANK_LOG-1:0]  enq_rank,
  input  logic [NUM_ENQ*RANK_LOG-1:0]  enq_send_time,
  input  logic                         deq_valid,
  output logic                         deq_ready,
  input  logic [RANK_LOG-1:0]          deq_cur_time,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_empty,
  output logic [ID_LOG-1:0]            resp_id,
  output logic [RANK_LOG-1:0]          resp_rank,
  output logic [RANK_LOG-1:0]          resp_send_time,
  output logic                         core_start,
  output logic                         core_op,
  output logic [ID_LOG-1:0]            core_id,
  output logic [RANK_LOG-1:0]          core_rank,
  output logic [RANK_LOG-1:0]          core_send_time,
  output logic [RANK_LOG-1:0]          core_cur_time,
  input  logic                         core_done,
  input  logic                         core_deq_valid,
  input  logic [ID_LOG-1:0]            core_deq_id,
  input  logic [RANK_LOG-1:0]          core_deq_rank,
  input  logic [RANK_LOG-1:0]          core_deq_send_time,
  output logic [ID_LOG:0]              occupancy,
  output logic                         full,
  output logic                         empty,
  output logic [1:0]                   state_dbg,
  output logic [SW-1:0]                starve_cnt_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam int LIST_SIZE = 1 << ID_LOG;

  logic [1:0]         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [SW-1:0]      starve_cnt;
  logic [NUM_ENQ-1:0] enq_elig;
  logic               any_enq;
  logic               starved;
  logic               grant_deq;
  logic               grant_enq;
  logic [PTR_W-1:0]   enq_sel;

  assign full           = (occupancy == (ID_LOG+1)'(LIST_SIZE));
  assign empty          = (occupancy == '0);
  assign state_dbg      = state;
  assign starve_cnt_dbg = starve_cnt;

  // Handshakes: a transfer happens in the cycle where valid & ready are both high.
  // Requesters hold valid and data until ready; ready is only raised in IDLE, and
  // resp_valid holds the response stable until resp_ready.
  assign enq_elig  = enq_valid & {NUM_ENQ{~full}};
  assign any_enq   = |enq_elig;
  assign starved   = (starve_cnt == SW'(STARVE_LIMIT)) && any_enq;
  assign grant_deq = (state == S_IDLE) && deq_valid && !starved;
  assign grant_enq = (state == S_IDLE) && any_enq && !grant_deq;

  assign deq_ready  = grant_deq;
  assign core_start = (state == S_ISSUE);
  assign resp_valid = (state == S_RESP);

  // Round-robin pick: scanning downward makes the port closest to rr_ptr win.
  always_comb begin
    enq_sel = '0;
    for (int k = NUM_ENQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_ENQ) idx = idx - NUM_ENQ;
      if (enq_elig[idx]) enq_sel = PTR_W'(idx);
    end
  end

  always_comb begin
    enq_ready = '0;
    if (grant_enq) enq_ready[enq_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      starve_cnt     <= '0;
      occupancy      <= '0;
      core_op        <= 1'b0;
      core_id        <= '0;
      core_rank      <= '0;
      core_send_time <= '0;
      core_cur_time  <= '0;
      resp_empty     <= 1'b0;
      resp_id        <= '0;
      resp_rank      <= '0;
      resp_send_time <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_deq) begin
            core_op       <= 1'b1;
            core_cur_time <= deq_cur_time;
            if (any_enq && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
            // Nothing stored: answer "empty" without touching the core.
            if (empty) begin
              resp_empty <= 1'b1;
              state      <= S_RESP;
            end else begin
              state <= S_ISSUE;
            end
          end else if (grant_enq) begin
            core_op        <= 1'b0;
            core_id        <= enq_id[int'(enq_sel)*ID_LOG +: ID_LOG];
            core_rank      <= enq_rank[int'(enq_sel)*RANK_LOG +: RANK_LOG];
            core_send_time <= enq_send_time[int'(enq_sel)*RANK_LOG +: RANK_LOG];
            starve_cnt     <= '0;
            rr_ptr         <= (int'(enq_sel) == NUM_ENQ - 1) ? '0 : enq_sel + 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            if (!core_op) begin
              if (!full) occupancy <= occupancy + 1'b1;
              state <= S_IDLE;
            end else begin
              if (core_deq_valid) begin
                if (!empty) occupancy <= occupancy - 1'b1;
                resp_id        <= core_deq_id;
                resp_rank      <= core_deq_rank;
                resp_send_time <= core_deq_send_time;
              end
              resp_empty <= !core_deq_valid;
              state      <= S_RESP;
            end
          end
        end
        default: begin
          if (resp_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  no_wrap_a: assert property (@(posedge clk) disable iff (rst)
    !(state == S_WAIT && core_done && !core_op && full));

endmodule

// File: tb/tb_pieo_op_scheduler.sv
// Directed bench for pieo_op_scheduler with a small core model and a response scoreboard.
module tb_pieo_op_scheduler;

  localparam int NE = 4;
  localparam int IL = 7;
  localparam int RL = 8;
  localparam int SL = 8;
  localparam int DONE_LAT = 3;

  logic            clk;
  logic            rst;
  logic [NE-1:0]   enq_valid;
  logic [NE-1:0]   enq_ready;
  logic [NE*IL-1:0] enq_id;
  logic [NE*RL-1:0] enq_rank;
  logic [NE*RL-1:0] enq_send_time;
  logic            deq_valid;
  logic            deq_ready;
  logic [RL-1:0]   deq_cur_time;
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_empty;
  logic [IL-1:0]   resp_id;
  logic [RL-1:0]   resp_rank;
  logic [RL-1:0]   resp_send_time;
  logic            core_start;
  logic            core_op;
  logic [IL-1:0]   core_id;
  logic [RL-1:0]   core_rank;
  logic [RL-1:0]   core_send_time;
  logic [RL-1:0]   core_cur_time;
  logic            core_done;
  logic            core_deq_valid;
  logic [IL-1:0]   core_deq_id;
  logic [RL-1:0]   core_deq_rank;
  logic [RL-1:0]   core_deq_send_time;
  logic [IL:0]     occupancy;
  logic            full;
  logic            empty;
  logic [1:0]      state_dbg;
  logic [3:0]      starve_cnt_dbg;

  pieo_op_scheduler #(.NUM_ENQ(NE), .ID_LOG(IL), .RANK_LOG(RL), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_id(enq_id),
    .enq_rank(enq_rank), .enq_send_time(enq_send_time),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_cur_time(deq_cur_time),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_empty(resp_empty),
    .resp_id(resp_id), .resp_rank(resp_rank), .resp_send_time(resp_send_time),
    .core_start(core_start), .core_op(core_op), .core_id(core_id),
    .core_rank(core_rank), .core_send_time(core_send_time), .core_cur_time(core_cur_time),
    .core_done(core_done), .core_deq_valid(core_deq_valid), .core_deq_id(core_deq_id),
    .core_deq_rank(core_deq_rank), .core_deq_send_time(core_deq_send_time),
    .occupancy(occupancy), .full(full), .empty(empty),
    .state_dbg(state_dbg), .starve_cnt_dbg(starve_cnt_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [23:0] exp_q[$];   // {empty, id, rank, send_time}
  logic [IL-1:0] exp_id [NE];
  logic [RL-1:0] exp_rank [NE];
  logic [RL-1:0] exp_st [NE];

  // ---------------- core model ----------------
  int start_cnt = 0;
  int done_cnt = -1;
  int force_req = 0;
  int force_seen = 0;
  logic model_auto = 1'b1;
  logic model_deq_valid = 1'b0;
  logic [IL-1:0] model_deq_id = '0;
  logic [RL-1:0] model_deq_rank = '0;
  logic [RL-1:0] model_deq_st = '0;

  always @(negedge clk) begin
    core_done = 1'b0;
    core_deq_valid = 1'b0;
    if (rst) begin
      done_cnt = -1;
    end else if (force_req != force_seen) begin
      force_seen = force_req;
      core_done = 1'b1;
    end else if (core_start) begin
      start_cnt++;
      done_cnt = DONE_LAT;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        done_cnt = -1;
        if (model_auto) begin
          core_done = 1'b1;
          core_deq_valid = model_deq_valid;
          core_deq_id = model_deq_id;
          core_deq_rank = model_deq_rank;
          core_deq_send_time = model_deq_st;
        end
      end
    end
  end

  // ---------------- checking / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_enq_grant(input int port, input int exp_occ, input string tag);
    int n = 0;
    #1;
    while (enq_ready == '0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_ready"}, 32'(enq_ready), 32'(1 << port));
    chk({tag, "_occ"}, 32'(occupancy), 32'(exp_occ));
    @(negedge clk); #1;
    chk({tag, "_start"}, 32'(core_start), 32'd1);
    chk({tag, "_op"}, 32'(core_op), 32'd0);
    chk({tag, "_id"}, 32'(core_id), 32'(exp_id[port]));
    chk({tag, "_rank"}, 32'(core_rank), 32'(exp_rank[port]));
    chk({tag, "_st"}, 32'(core_send_time), 32'(exp_st[port]));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    #1;
    while (state_dbg != 2'd0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_idle"}, 32'(state_dbg), 32'd0);
  endtask

  task automatic take_resp(input string tag);
    int n = 0;
    logic [23:0] e;
    resp_ready = 1'b1;
    #1;
    while (!resp_valid && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_queued"}, 32'(exp_q.size() != 0), 32'd1);
    if (resp_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_empty"}, 32'(resp_empty), 32'(e[23]));
      if (!e[23]) begin
        chk({tag, "_id"}, 32'(resp_id), 32'(e[22:16]));
        chk({tag, "_rank"}, 32'(resp_rank), 32'(e[15:8]));
        chk({tag, "_st"}, 32'(resp_send_time), 32'(e[7:0]));
      end
    end
    @(negedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int base_starts;
    int deq_cnt;
    logic got_enq;
    logic [23:0] e;

    rst = 1'b1;
    enq_valid = '0;
    deq_valid = 1'b0;
    deq_cur_time = '0;
    resp_ready = 1'b0;
    enq_id = '0;
    enq_rank = '0;
    enq_send_time = '0;
    core_deq_id = '0;
    core_deq_rank = '0;
    core_deq_send_time = '0;
    for (int p = 0; p < NE; p++) begin
      exp_id[p]   = IL'(10 + p * 5);
      exp_rank[p] = RL'($urandom_range(0, 255));
      exp_st[p]   = RL'($urandom_range(0, 255));
      enq_id[p*IL +: IL]        = exp_id[p];
      enq_rank[p*RL +: RL]      = exp_rank[p];
      enq_send_time[p*RL +: RL] = exp_st[p];
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd0);
    chk("rst_deq_ready", 32'(deq_ready), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_empty", 32'(resp_empty), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_starve", 32'(starve_cnt_dbg), 32'd0);
    chk("rst_core_id", 32'(core_id), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);

    // Dequeue on an empty list bypasses the core.
    base_starts = start_cnt;
    deq_cur_time = 8'd7;
    deq_valid = 1'b1;
    #1;
    chk("edeq_ready", 32'(deq_ready), 32'd1);
    chk("edeq_no_start_t", 32'(core_start), 32'd0);
    exp_q.push_back({1'b1, 23'd0});
    @(negedge clk); #1;
    deq_valid = 1'b0;
    chk("edeq_resp_t1", 32'(resp_valid), 32'd1);
    chk("edeq_empty_t1", 32'(resp_empty), 32'd1);
    take_resp("edeq");
    chk("edeq_no_core", 32'(start_cnt), 32'(base_starts));

    // All four ports requesting: round-robin 0,1,2,3,0.
    enq_valid = 4'hf;
    for (int g = 0; g < 5; g++) wait_enq_grant(g % NE, g, "rr");
    enq_valid = '0;
    wait_idle("rr_done");
    chk("rr_occ5", 32'(occupancy), 32'd5);

    // Fill the list through port 0.
    enq_valid = 4'b0001;
    n = 0;
    while (!full && n < 3000) begin
      @(negedge clk); #1; n++;
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_occ", 32'(occupancy), 32'd128);
    enq_valid = 4'b0100;
    repeat (4) begin
      @(negedge clk); #1;
      chk("full_hold", 32'(enq_ready), 32'd0);
    end

    // One successful dequeue frees a slot; port 2 goes next.
    model_deq_valid = 1'b1;
    model_deq_id = 7'd9;
    model_deq_rank = 8'd3;
    model_deq_st = 8'd2;
    deq_cur_time = 8'd20;
    deq_valid = 1'b1;
    #1;
    chk("hit_deq_ready", 32'(deq_ready), 32'd1);
    chk("hit_enq_block", 32'(enq_ready), 32'd0);
    exp_q.push_back({1'b0, 7'd9, 8'd3, 8'd2});
    @(negedge clk); #1;
    deq_valid = 1'b0;
    take_resp("hit");
    chk("hit_full", 32'(full), 32'd0);
    chk("hit_occ", 32'(occupancy), 32'd127);
    wait_enq_grant(2, 127, "after_full");
    enq_valid = '0;
    wait_idle("refill");
    chk("refill_occ", 32'(occupancy), 32'd128);

    // Second successful dequeue with different data.
    model_deq_id = 7'd33;
    model_deq_rank = 8'd77;
    model_deq_st = 8'd4;
    deq_cur_time = 8'd11;
    deq_valid = 1'b1;
    #1;
    chk("hit2_deq_ready", 32'(deq_ready), 32'd1);
    exp_q.push_back({1'b0, 7'd33, 8'd77, 8'd4});
    @(negedge clk); #1;
    deq_valid = 1'b0;
    chk("hit2_start", 32'(core_start), 32'd1);
    chk("hit2_op", 32'(core_op), 32'd1);
    chk("hit2_cur_time", 32'(core_cur_time), 32'd11);
    take_resp("hit2");
    chk("hit2_occ", 32'(occupancy), 32'd127);

    // Starvation: dequeues (none eligible at cur_time 5) vs a port-1 enqueue.
    model_deq_valid = 1'b0;
    deq_cur_time = 8'd5;
    resp_ready = 1'b1;
    deq_valid = 1'b1;
    enq_valid = 4'b0010;
    deq_cnt = 0;
    got_enq = 1'b0;
    n = 0;
    while (!got_enq && n < 400) begin
      #1;
      if (deq_ready) begin
        deq_cnt++;
        exp_q.push_back({1'b1, 23'd0});
      end
      if (core_start) chk("starve_cur_time", 32'(core_cur_time), 32'd5);
      if (resp_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("starve_resp_empty", 32'(resp_empty), 32'(e[23]));
        chk("starve_occ_kept", 32'(occupancy), 32'd127);
      end
      if (enq_ready != '0) begin
        got_enq = 1'b1;
        chk("starve_enq_port", 32'(enq_ready), 32'b0010);
        chk("starve_deq_cnt", 32'(deq_cnt), 32'(SL));
        chk("starve_occ", 32'(occupancy), 32'd127);
      end else begin
        @(negedge clk); n++;
      end
    end
    chk("starve_enq_seen", 32'(got_enq), 32'd1);
    @(negedge clk); #1;
    chk("starve_cleared", 32'(starve_cnt_dbg), 32'd0);
    chk("starve_q_drained", 32'(exp_q.size()), 32'd0);
    deq_valid = 1'b0;
    enq_valid = '0;
    resp_ready = 1'b0;
    wait_idle("starve_end");
    chk("starve_end_occ", 32'(occupancy), 32'd128);

    // Reset while a dequeue waits on the core; a late core_done must be ignored.
    model_auto = 1'b0;
    deq_valid = 1'b1;
    #1;
    chk("rstw_deq_ready", 32'(deq_ready), 32'd1);
    @(negedge clk); #1;
    deq_valid = 1'b0;
    n = 0;
    while (state_dbg != 2'd2 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rstw_in_wait", 32'(state_dbg), 32'd2);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("rstw_state", 32'(state_dbg), 32'd0);
    chk("rstw_occ", 32'(occupancy), 32'd0);
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw_empty", 32'(empty), 32'd1);
    force_req++;
    model_auto = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("late_done_state", 32'(state_dbg), 32'd0);
    chk("late_done_occ", 32'(occupancy), 32'd0);
    chk("late_done_resp", 32'(resp_valid), 32'd0);
    chk("late_done_start", 32'(core_start), 32'd0);

    deq_valid = 1'b1;
    #1;
    chk("post_rst_deq_ready", 32'(deq_ready), 32'd1);
    exp_q.push_back({1'b1, 23'd0});
    @(negedge clk); #1;
    deq_valid = 1'b0;
    take_resp("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
